spi_dac_master: RTL and testbench

Parametrised SPI master for the oscilloscope's DAC outputs, replacing the fixed 16-bit single-DAC transfer logic. It accepts one word per valid/ready handshake from the system-clock domain and generates SCLK internally from `clk` with a programmable divider. It drives one of `NUM_CH` chip selects per frame, in SPI mode 0, with a configurable inter-frame gap.

---
 rtl/spi_dac_master_pkg.sv | 23 ++
 rtl/spi_dac_master_if.sv | 21 ++
 rtl/spi_dac_master_clk_div.sv | 30 +++
 rtl/spi_dac_master.sv | 134 +++++++++++++
 tb/tb_spi_dac_master.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_dac_master_pkg.sv
// Shared types and width helpers for the DAC SPI master.
package spi_dac_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Channel index width; a single DAC still gets a one-bit index.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/spi_dac_master_if.sv
// Word request bus into the DAC SPI master.
//
// Handshake: a word transfers on a rising clk edge where tx_valid and
// tx_ready are both high. The requester keeps tx_valid, tx_data and tx_ch
// stable until that edge; tx_valid may not depend on tx_ready. tx_ready is
// a register and never depends combinationally on tx_valid.
interface spi_dac_master_if
  import spi_dac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_width(NUM_CH)
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [CH_W-1:0]   tx_ch;

  modport master (output tx_valid, output tx_data, output tx_ch, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_ch, output tx_ready);
endinterface

// File: rtl/spi_dac_master_clk_div.sv
// Divider tick generator: one-cycle tick every CLK_DIV clk cycles,
// phase-aligned to the last synchronous clear.
module spi_clk_div
  import spi_dac_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-CLK_DIV counter, restarted by clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/spi_dac_master.sv
// SPI mode-0 master for the scope DAC outputs: one word per handshake,
// one chip select per frame, programmable SCLK divider and CS gap.
module spi_dac_master
  import spi_dac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int CH_W      = ch_width(NUM_CH),
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_dac_master_if.slave   tx,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CH-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);
  localparam int BW = cnt_width(DATA_W);
  localparam int GW = cnt_width(CS_GAP);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);
  localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);

  state_t            state;
  logic              ready_q;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              tick;
  logic              accept;
  logic              ch_ok;

  // Any handshake counts as an accept; out-of-range channels are dropped.
  assign accept    = (state == IDLE) && ready_q && tx.tx_valid;
  assign ch_ok     = (int'(tx.tx_ch) < NUM_CH);
  assign tx.tx_ready = ready_q;
  assign dbg_state = state;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (accept),
    .tick   (tick)
  );

  // Frame sequencer with registered SPI pins, handshake and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept && ch_ok) begin
            ready_q <= 1'b0;
            busy    <= 1'b1;
            sr      <= tx.tx_data;
            mosi    <= (LSB_FIRST != 0) ? tx.tx_data[0] : tx.tx_data[DATA_W-1];
            bit_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
              cs_n[i] <= (int'(tx.tx_ch) != i);
            end
            state   <= SETUP;
          end
        end
        SETUP: begin
          // First rising edge after a half-period of data setup.
          if (tick) begin
            sclk    <= 1'b1;
            bit_cnt <= BW'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + BW'(1);
            end else begin
              sclk <= 1'b0;
              // The last falling edge leaves the final bit in place for hold.
              if (bit_cnt == LAST_BIT) begin
                state <= HOLD;
              end else if (LSB_FIRST != 0) begin
                sr   <= sr >> 1;
                mosi <= sr[1];
              end else begin
                sr   <= sr << 1;
                mosi <= sr[DATA_W-2];
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n    <= '1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == LAST_GAP) begin
              ready_q <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_dac_master.sv
// Bench for spi_dac_master: three configurations (defaults, 12-bit LSB-first
// at CLK_DIV=1, three channels), scoreboarded frame contents and timing.
module tb_spi_dac_master;
  import spi_dac_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- DUT A: defaults ----------------
  spi_dac_master_if #(.DATA_W(16), .NUM_CH(2)) a_if ();
  logic a_sclk, a_mosi, a_busy, a_done;
  logic [1:0] a_cs_n;
  state_t a_state;
  spi_dac_master #(.DATA_W(16), .NUM_CH(2), .CLK_DIV(4), .CS_GAP(2), .LSB_FIRST(0)) u_a (
    .clk(clk), .reset_n(reset_n), .tx(a_if), .sclk(a_sclk), .mosi(a_mosi),
    .cs_n(a_cs_n), .busy(a_busy), .done(a_done), .dbg_state(a_state));

  // ---------------- DUT B: 12-bit, LSB first, CLK_DIV=1 ----------------
  spi_dac_master_if #(.DATA_W(12), .NUM_CH(2)) b_if ();
  logic b_sclk, b_mosi, b_busy, b_done;
  logic [1:0] b_cs_n;
  state_t b_state;
  spi_dac_master #(.DATA_W(12), .NUM_CH(2), .CLK_DIV(1), .CS_GAP(2), .LSB_FIRST(1)) u_b (
    .clk(clk), .reset_n(reset_n), .tx(b_if), .sclk(b_sclk), .mosi(b_mosi),
    .cs_n(b_cs_n), .busy(b_busy), .done(b_done), .dbg_state(b_state));

  // ---------------- DUT C: three channels ----------------
  spi_dac_master_if #(.DATA_W(16), .NUM_CH(3)) c_if ();
  logic c_sclk, c_mosi, c_busy, c_done;
  logic [2:0] c_cs_n;
  state_t c_state;
  spi_dac_master #(.DATA_W(16), .NUM_CH(3), .CLK_DIV(4), .CS_GAP(2), .LSB_FIRST(0)) u_c (
    .clk(clk), .reset_n(reset_n), .tx(c_if), .sclk(c_sclk), .mosi(c_mosi),
    .cs_n(c_cs_n), .busy(c_busy), .done(c_done), .dbg_state(c_state));

  // ---------------- scoreboards ----------------
  logic [15:0] a_exp_q[$];
  logic [1:0]  a_pat_q[$];
  logic [11:0] b_exp_q[$];

  logic        a_sclk_q, a_in, a_gap_run;
  int          a_bits, a_cs_low, a_gap, a_gap_last;
  int          a_done_cnt = 0, a_acc_cnt = 0, a_both_low = 0, a_stray = 0;
  logic [15:0] a_val, a_exp_d;
  logic [1:0]  a_pat, a_exp_p;

  // Monitor A: rebuild each frame from SCLK rises and compare on CS release.
  always @(negedge clk) begin
    if (!reset_n) begin
      a_in = 0; a_bits = 0; a_val = '0; a_cs_low = 0;
      a_gap_run = 0; a_gap = 0; a_sclk_q = 0;
    end else begin
      if (a_if.tx_valid && a_if.tx_ready) a_acc_cnt++;
      if (a_done) a_done_cnt++;
      if (a_cs_n != 2'b11) begin
        if (!a_in) begin
          a_in = 1; a_bits = 0; a_val = '0; a_cs_low = 0; a_pat = a_cs_n;
          if (a_gap_run) a_gap_last = a_gap;
          a_gap_run = 0;
        end
        if (a_cs_n == 2'b00) a_both_low++;
        a_cs_low++;
        if (a_sclk && !a_sclk_q) begin
          a_val = {a_val[14:0], a_mosi};
          a_bits++;
        end
      end else begin
        if (a_sclk) a_stray++;
        if (a_in) begin
          a_in = 0; a_gap_run = 1; a_gap = 0;
          check("a_done_at_cs_rise", a_done, 1);
          check("a_frame_expected", a_exp_q.size() != 0, 1);
          if (a_exp_q.size() != 0) begin
            a_exp_d = a_exp_q.pop_front();
            a_exp_p = a_pat_q.pop_front();
            check("a_data", a_val, a_exp_d);
            check("a_bit_count", a_bits, 16);
            check("a_cs_pattern", a_pat, a_exp_p);
            check("a_cs_low_cycles", a_cs_low, 132);
          end
        end
        if (a_gap_run) a_gap++;
      end
      a_sclk_q = a_sclk;
    end
  end

  logic        b_sclk_q, b_in;
  int          b_bits, b_cs_low, b_done_cnt = 0;
  logic [11:0] b_val, b_exp_d;

  // Monitor B: sample order i goes to bit i, so LSB-first data reads back as-is.
  always @(negedge clk) begin
    if (!reset_n) begin
      b_in = 0; b_sclk_q = 0;
    end else begin
      if (b_done) b_done_cnt++;
      if (b_cs_n != 2'b11) begin
        if (!b_in) begin
          b_in = 1; b_bits = 0; b_val = '0; b_cs_low = 0;
        end
        b_cs_low++;
        if (b_sclk && !b_sclk_q) begin
          if (b_bits < 12) b_val[b_bits] = b_mosi;
          b_bits++;
        end
      end else if (b_in) begin
        b_in = 0;
        check("b_frame_expected", b_exp_q.size() != 0, 1);
        if (b_exp_q.size() != 0) begin
          b_exp_d = b_exp_q.pop_front();
          check("b_data", b_val, b_exp_d);
          check("b_bit_count", b_bits, 12);
          check("b_cs_low_cycles", b_cs_low, 25);
        end
      end
      b_sclk_q = b_sclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [15:0] d, input logic ch);
    int t;
    @(posedge clk); #1;
    a_if.tx_data = d; a_if.tx_ch = ch; a_if.tx_valid = 1'b1;
    t = 0;
    while (t < 1000) begin
      @(negedge clk);
      if (a_if.tx_ready) break;
      t++;
    end
    check("a_accept_in_time", t < 1000, 1);
    @(posedge clk); #1;
    a_if.tx_valid = 1'b0;
  endtask

  // Counts clk edges from the accept edge until tx_ready is seen high.
  task automatic wait_ready_a(output int n);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (a_if.tx_ready) break;
      @(posedge clk);
      n++;
    end
    check("a_ready_in_time", n < 1000, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, t, acc0, viol, c_dn;
    reset_n = 1'b0;
    a_if.tx_valid = 0; a_if.tx_data = '0; a_if.tx_ch = '0;
    b_if.tx_valid = 0; b_if.tx_data = '0; b_if.tx_ch = '0;
    c_if.tx_valid = 0; c_if.tx_data = '0; c_if.tx_ch = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_cs_n", a_cs_n, 2'b11);
    check("rst_ready", a_if.tx_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_state", a_state, IDLE);
    check("rst_c_cs_n", c_cs_n, 3'b111);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("a_ready_after_reset", a_if.tx_ready, 1);
    check("b_ready_after_reset", b_if.tx_ready, 1);

    // Single frame, defaults.
    a_exp_q.push_back(16'hA5C3); a_pat_q.push_back(2'b01);
    send_a(16'hA5C3, 1'b1);
    wait_ready_a(n);
    check("a_ready_latency", n, 140);
    #1 check("a_done_once", a_done_cnt, 1);

    // 12-bit LSB-first frame on B.
    b_exp_q.push_back(12'h801);
    @(posedge clk); #1;
    b_if.tx_data = 12'h801; b_if.tx_ch = 1'b0; b_if.tx_valid = 1'b1;
    t = 0;
    while (t < 100) begin @(negedge clk); if (b_if.tx_ready) break; t++; end
    @(posedge clk); #1;
    b_if.tx_valid = 1'b0;
    check("b_busy_after_accept", b_busy, 1);
    n = 0;
    while (n < 200) begin @(negedge clk); if (b_if.tx_ready) break; @(posedge clk); n++; end
    check("b_ready_latency", n, 27);
    #1;
    check("b_done_once", b_done_cnt, 1);
    check("b_state_idle", b_state, IDLE);

    // Back-to-back: valid held across two words.
    a_exp_q.push_back(16'h1234); a_pat_q.push_back(2'b10);
    a_exp_q.push_back(16'hFEDC); a_pat_q.push_back(2'b01);
    @(posedge clk); #1;
    a_if.tx_data = 16'h1234; a_if.tx_ch = 1'b0; a_if.tx_valid = 1'b1;
    t = 0;
    while (t < 1000) begin @(negedge clk); if (a_if.tx_ready) break; t++; end
    @(posedge clk); #1;
    a_if.tx_data = 16'hFEDC; a_if.tx_ch = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (a_if.tx_ready) begin @(posedge clk); n++; break; end
      @(posedge clk); n++;
    end
    #1 a_if.tx_valid = 1'b0;
    check("a_b2b_period", n, 141);
    wait_ready_a(n);
    #1;
    check("a_gap_cycles", a_gap_last, 9);
    check("a_never_both_low", a_both_low, 0);

    // Requests while busy are ignored.
    a_exp_q.push_back(16'hC35A); a_pat_q.push_back(2'b10);
    acc0 = a_acc_cnt;
    send_a(16'hC35A, 1'b0);
    @(negedge clk);
    check("a_setup_state", a_state, SETUP);
    check("a_setup_cs_n", a_cs_n, 2'b10);
    check("a_setup_mosi", a_mosi, 1);
    check("a_setup_sclk", a_sclk, 0);
    check("a_setup_busy", a_busy, 1);
    check("a_setup_ready", a_if.tx_ready, 0);
    repeat (40) begin
      @(posedge clk); #1;
      a_if.tx_valid = 1'($urandom_range(0, 1));
      a_if.tx_data  = 16'($urandom);
      a_if.tx_ch    = 1'($urandom_range(0, 1));
    end
    a_if.tx_valid = 1'b0;
    wait_ready_a(n);
    #1 check("a_toggle_accepts", a_acc_cnt - acc0, 1);

    // Out-of-range channel on C is swallowed quietly.
    @(posedge clk); #1;
    c_if.tx_ch = 2'd3; c_if.tx_data = 16'($urandom); c_if.tx_valid = 1'b1;
    t = 0;
    while (t < 100) begin @(negedge clk); if (c_if.tx_ready) break; t++; end
    check("c_drop_accepted", c_if.tx_ready, 1);
    @(posedge clk); #1;
    c_if.tx_valid = 1'b0;
    viol = 0;
    repeat (40) begin
      @(negedge clk);
      if (c_sclk || c_cs_n != 3'b111 || c_done || !c_if.tx_ready || c_busy || c_state != IDLE)
        viol++;
    end
    check("c_drop_quiet", viol, 0);
    // A legal word to the third channel.
    @(posedge clk); #1;
    c_if.tx_ch = 2'd2; c_if.tx_data = 16'h0F0F; c_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    c_if.tx_valid = 1'b0;
    @(negedge clk);
    check("c_ch2_cs_n", c_cs_n, 3'b011);
    check("c_ch2_busy", c_busy, 1);
    c_dn = 0; t = 0;
    while (t < 1000) begin
      @(negedge clk);
      if (c_done) c_dn++;
      if (c_if.tx_ready) break;
      t++;
    end
    check("c_ch2_done_once", c_dn, 1);

    // Reset in the middle of a frame.
    send_a(16'($urandom), 1'b0);
    t = 0;
    while (t < 2000) begin @(negedge clk); #1; if (a_bits == 5) break; t++; end
    check("a_fifth_rise_seen", a_bits, 5);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_sclk", a_sclk, 0);
    check("mid_rst_mosi", a_mosi, 0);
    check("mid_rst_cs_n", a_cs_n, 2'b11);
    check("mid_rst_ready", a_if.tx_ready, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_state", a_state, IDLE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    a_exp_q.push_back(16'h0001); a_pat_q.push_back(2'b01);
    send_a(16'h0001, 1'b1);
    wait_ready_a(n);
    check("a_ready_latency_after_rst", n, 140);

    #1;
    check("a_done_total", a_done_cnt, 5);
    check("a_accept_total", a_acc_cnt, 6);
    check("a_no_sclk_outside_frame", a_stray, 0);
    check("a_queue_drained", a_exp_q.size(), 0);
    check("b_queue_drained", b_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
